// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch / count-down blocks.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CD_SET    = 2'b00,
    CD_RUN    = 2'b01,
    CD_PAUSED = 2'b10,
    CD_DONE   = 2'b11
  } cd_state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_ONE  = 8'h01;

endpackage

// File: rtl/bcd_dec2.sv
// Two-digit BCD decrement. Ones 0 borrows from tens and becomes 9.
// is_one flags an input of 01, the last step before reaching 00.
module bcd_dec2
  import stopwatch_pkg::*;
(
  input  logic [7:0] bcd_in,
  output logic [7:0] bcd_out,
  output logic       is_one
);

  // Digit-wise decrement with borrow from ones into tens.
  always_comb begin
    bcd_out = bcd_in;
    if (bcd_in[3:0] == 4'd0) begin
      bcd_out[3:0] = 4'd9;
      bcd_out[7:4] = (bcd_in[7:4] == 4'd0) ? 4'd9 : bcd_in[7:4] - 4'd1;
    end else begin
      bcd_out[3:0] = bcd_in[3:0] - 4'd1;
    end
  end

  assign is_one = (bcd_in == BCD_ONE);

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD count-down timer with preset entry, pause and expiry alarm.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SET    | editing the preset digits with inc_one / inc_ten
//   RUN    | decrementing once per second_tick
//   PAUSED | holding the current value, ticks ignored
//   DONE   | reached 00, expired high, alarm blinks per second_tick
//
// Within a cycle: clear > start_pause > second_tick > digit increments.
module bcd_countdown
  import stopwatch_pkg::*;
#(
  parameter int TENS_MAX = 9,
  parameter int ONES_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       second_tick,
  input  logic       inc_one,
  input  logic       inc_ten,
  input  logic       start_pause,
  input  logic       clear,
  output logic [7:0] bcd_num,
  output logic       expired,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [3:0] TENS_LIM = 4'(TENS_MAX);
  localparam logic [3:0] ONES_LIM = 4'(ONES_MAX);

  cd_state_t  state_q, state_d;
  logic [7:0] bcd_q, bcd_d;
  logic [7:0] preset_q, preset_d;
  logic       alarm_q, alarm_d;
  logic       expired_q;
  logic [7:0] bcd_dec;
  logic       bcd_is_one;

  bcd_dec2 u_dec (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_dec),
    .is_one  (bcd_is_one)
  );

  // State, value, preset and alarm registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CD_SET;
      bcd_q     <= BCD_ZERO;
      preset_q  <= BCD_ZERO;
      alarm_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      preset_q  <= preset_d;
      alarm_q   <= alarm_d;
      expired_q <= (state_d == CD_DONE);
    end
  end

  // Next-state, value and alarm decode with the input priority above.
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    preset_d = preset_q;
    alarm_d  = alarm_q;
    if (clear) begin
      // In SET clear zeroes the entry; elsewhere it reloads the last preset.
      bcd_d   = (state_q == CD_SET) ? BCD_ZERO : preset_q;
      alarm_d = 1'b0;
      state_d = CD_SET;
    end else if (start_pause) begin
      case (state_q)
        CD_SET: begin
          if (bcd_q != BCD_ZERO) begin
            preset_d = bcd_q;
            state_d  = CD_RUN;
          end
        end
        CD_RUN:    state_d = CD_PAUSED;
        CD_PAUSED: state_d = CD_RUN;
        CD_DONE: begin
          bcd_d   = preset_q;
          alarm_d = 1'b0;
          state_d = CD_RUN;
        end
        default:   state_d = CD_SET;
      endcase
    end else begin
      if (second_tick && state_q == CD_RUN) begin
        if (bcd_is_one) begin
          bcd_d   = BCD_ZERO;
          alarm_d = 1'b1;
          state_d = CD_DONE;
        end else begin
          bcd_d = bcd_dec;
        end
      end else if (second_tick && state_q == CD_DONE) begin
        alarm_d = ~alarm_q;
      end
      // Ticks have no effect in SET, so they do not block digit entry.
      if (state_q == CD_SET) begin
        if (inc_one)
          bcd_d[3:0] = (bcd_q[3:0] >= ONES_LIM) ? 4'd0 : bcd_q[3:0] + 4'd1;
        if (inc_ten)
          bcd_d[7:4] = (bcd_q[7:4] >= TENS_LIM) ? 4'd0 : bcd_q[7:4] + 4'd1;
      end
    end
  end

  assign bcd_num = bcd_q;
  assign state   = state_q;
  assign alarm   = alarm_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench for bcd_countdown: stimulus pushes expected outputs tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_bcd_countdown;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_CLR  = 5'b10000;
  localparam logic [4:0] P_SP   = 5'b01000;
  localparam logic [4:0] P_TK   = 5'b00100;
  localparam logic [4:0] P_TEN  = 5'b00010;
  localparam logic [4:0] P_ONE  = 5'b00001;

  localparam logic [1:0] S_SET = 2'b00, S_RUN = 2'b01, S_PAU = 2'b10, S_DONE = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       second_tick = 1'b0, inc_one = 1'b0, inc_ten = 1'b0;
  logic       start_pause = 1'b0, clear = 1'b0;
  logic [7:0] bcd_num;
  logic       expired, alarm;
  logic [1:0] state;

  logic       b_inc_ten = 1'b0;
  logic       b_zero = 1'b0;
  logic [7:0] b_bcd;
  logic       b_expired, b_alarm;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    string      tag;
    logic [11:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  bcd_countdown dut (
    .clk(clk), .rst(rst), .second_tick(second_tick), .inc_one(inc_one),
    .inc_ten(inc_ten), .start_pause(start_pause), .clear(clear),
    .bcd_num(bcd_num), .expired(expired), .alarm(alarm), .state(state)
  );

  bcd_countdown #(.TENS_MAX(5), .ONES_MAX(9)) dut_t5 (
    .clk(clk), .rst(rst), .second_tick(b_zero), .inc_one(b_zero),
    .inc_ten(b_inc_ten), .start_pause(b_zero), .clear(b_zero),
    .bcd_num(b_bcd), .expired(b_expired), .alarm(b_alarm), .state(b_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every expectation in the cycle it falls due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_item_t it;
      it = sb.pop_front();
      if (it.due != cyc)
        chk({it.tag, " (missed)"}, 32'(it.due), 32'(cyc));
      else
        chk(it.tag, {20'd0, bcd_num, state, expired, alarm}, {20'd0, it.exp});
    end
  end

  // One pulse cycle; the result is due right after the next rising edge.
  task automatic step(input string tag, input logic [4:0] p,
                      input logic [7:0] b, input logic [1:0] s, input logic a);
    sb_item_t it;
    @(posedge clk); #2;
    {clear, start_pause, second_tick, inc_ten, inc_one} = p;
    it.due = cyc + 1;
    it.tag = tag;
    it.exp = {b, s, (s == S_DONE), a};
    sb.push_back(it);
    @(posedge clk); #2;
    {clear, start_pause, second_tick, inc_ten, inc_one} = P_NONE;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  logic [7:0] down11 [11] = '{8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                              8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] ones12 [12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                              8'h37, 8'h38, 8'h39, 8'h30, 8'h31, 8'h32};
  logic [7:0] down5  [5]  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] tens6  [6]  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00};

  initial begin
    #3;
    chk("reset outputs", {20'd0, bcd_num, state, expired, alarm}, 32'h0);
    chk("reset t5 outputs", {20'd0, b_bcd, b_state, b_expired, b_alarm}, 32'h0);
    #10 rst = 1'b0;

    // Entry and wrap.
    step("ten 1", P_TEN, 8'h10, S_SET, 1'b0);
    step("ten 2", P_TEN, 8'h20, S_SET, 1'b0);
    step("ten 3", P_TEN, 8'h30, S_SET, 1'b0);
    for (int i = 0; i < 12; i++) step($sformatf("one %0d", i + 1), P_ONE, ones12[i], S_SET, 1'b0);
    step("tick in SET", P_TK, 8'h32, S_SET, 1'b0);
    step("clear in SET", P_CLR, 8'h00, S_SET, 1'b0);

    // Borrow and expiry from 11.
    step("both digits", P_TEN | P_ONE, 8'h11, S_SET, 1'b0);
    step("start 11", P_SP, 8'h11, S_RUN, 1'b0);
    for (int i = 0; i < 11; i++)
      step($sformatf("down11 %0d", i), P_TK, down11[i], (i == 10) ? S_DONE : S_RUN, i == 10);
    step("alarm toggle 0", P_TK, 8'h00, S_DONE, 1'b0);
    step("alarm toggle 1", P_TK, 8'h00, S_DONE, 1'b1);
    step("inc in DONE", P_ONE, 8'h00, S_DONE, 1'b1);

    // Pause priority at 25.
    step("clear DONE reload", P_CLR, 8'h11, S_SET, 1'b0);
    step("clear zero", P_CLR, 8'h00, S_SET, 1'b0);
    step("set 20", P_TEN, 8'h10, S_SET, 1'b0);
    step("set 20b", P_TEN, 8'h20, S_SET, 1'b0);
    for (int i = 1; i <= 5; i++) step("set 2x", P_ONE, 8'h20 + 8'(i), S_SET, 1'b0);
    step("start 25", P_SP, 8'h25, S_RUN, 1'b0);
    step("pause+tick", P_SP | P_TK, 8'h25, S_PAU, 1'b0);
    for (int i = 0; i < 3; i++) step("tick paused", P_TK, 8'h25, S_PAU, 1'b0);
    step("inc paused", P_ONE | P_TEN, 8'h25, S_PAU, 1'b0);
    step("resume+tick", P_SP | P_TK, 8'h25, S_RUN, 1'b0);
    step("tick 24", P_TK, 8'h24, S_RUN, 1'b0);
    step("inc in RUN", P_ONE, 8'h24, S_RUN, 1'b0);
    step("clear+sp RUN", P_CLR | P_SP, 8'h25, S_SET, 1'b0);

    // Restart and reload with preset 05.
    step("clear zero 2", P_CLR, 8'h00, S_SET, 1'b0);
    for (int i = 1; i <= 5; i++) step("set 0x", P_ONE, 8'(i), S_SET, 1'b0);
    step("start+tick 05", P_SP | P_TK, 8'h05, S_RUN, 1'b0);
    for (int i = 0; i < 5; i++)
      step("down5", P_TK, down5[i], (i == 4) ? S_DONE : S_RUN, i == 4);
    step("restart", P_SP, 8'h05, S_RUN, 1'b0);
    step("clear reload 05", P_CLR, 8'h05, S_SET, 1'b0);
    step("clear again", P_CLR, 8'h00, S_SET, 1'b0);

    // Zero start ignored.
    step("zero start", P_SP, 8'h00, S_SET, 1'b0);

    // Async reset mid-run at 47.
    for (int i = 1; i <= 4; i++) step("set x0", P_TEN, {4'(i), 4'h0}, S_SET, 1'b0);
    for (int i = 1; i <= 7; i++) step("set 4x", P_ONE, {4'h4, 4'(i)}, S_SET, 1'b0);
    step("start 47", P_SP, 8'h47, S_RUN, 1'b0);
    drain();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async reset", {20'd0, bcd_num, state, expired, alarm}, 32'h0);
    @(negedge clk); rst = 1'b0;
    step("clear after reset", P_CLR, 8'h00, S_SET, 1'b0);
    step("start after reset", P_SP, 8'h00, S_SET, 1'b0);
    drain();

    // TENS_MAX = 5 instance: tens wraps after 5.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2 b_inc_ten = 1'b1;
      @(posedge clk); #2 b_inc_ten = 1'b0;
      chk($sformatf("t5 ten %0d", i + 1), {24'd0, b_bcd}, {24'd0, tens6[i]});
    end
    chk("t5 state", {30'd0, b_state}, {30'd0, S_SET});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
